// File: rtl/ptr_list_writer_pkg.sv
// ---------------------------------------------------------------------------
// ptr_list_writer_pkg
// Shared constants and types for the pointer-list writer:
//   n        number of list nodes (node 0 is the null / terminator pointer)
//   w_ptr    pointer width
//   ptr_t    node pointer type
//   cmd_op_e command opcode encoding
//   state_e  controller states
//   reset_next() power-up contents of the next-pointer table
// ---------------------------------------------------------------------------
package ptr_list_writer_pkg;

   localparam int n     = 256;
   localparam int w_ptr = $clog2(n);

   typedef logic [w_ptr-1:0] ptr_t;

   typedef enum logic [1:0] {
      OP_NEW    = 2'd0,
      OP_APPEND = 2'd1,
      OP_FREE   = 2'd2,
      OP_RSVD   = 2'd3
   } cmd_op_e;

   typedef enum logic {
      ST_IDLE      = 1'b0,
      ST_FREE_WALK = 1'b1
   } state_e;

   // After reset every real node is on the free list in ascending order:
   // 1 -> 2 -> ... -> n-1 -> 0. Node 0 always points at itself (null).
   function automatic ptr_t reset_next(input int i);
      if (i >= 1 && i <= n - 2) return ptr_t'(i + 1);
      else                      return '0;
   endfunction

endpackage

// File: rtl/ptr_list_writer_table.sv
// ---------------------------------------------------------------------------
// ptr_table
// Next-pointer table next[0..n-1] with two write ports and three
// combinational read ports.
//   clk, rst            clock, synchronous active-high reset (loads the
//                       initial free-list threading)
//   wa_en_i/addr/data   write port A
//   wb_en_i/addr/data   write port B (wins over A on an address clash)
//   ra/rb/rc_addr_i     read addresses
//   ra/rb/rc_data_o     next[addr], combinational from register state
// Writes to node 0 are dropped so next[0] always reads 0.
// ---------------------------------------------------------------------------
module ptr_table
   import ptr_list_writer_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic wa_en_i,
   input  ptr_t wa_addr_i,
   input  ptr_t wa_data_i,
   input  logic wb_en_i,
   input  ptr_t wb_addr_i,
   input  ptr_t wb_data_i,
   input  ptr_t ra_addr_i,
   output ptr_t ra_data_o,
   input  ptr_t rb_addr_i,
   output ptr_t rb_data_o,
   input  ptr_t rc_addr_i,
   output ptr_t rc_data_o
);

   ptr_t mem_q [n];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < n; i++) mem_q[i] <= reset_next(i);
      end else begin
         if (wa_en_i && wa_addr_i != '0) mem_q[wa_addr_i] <= wa_data_i;
         if (wb_en_i && wb_addr_i != '0) mem_q[wb_addr_i] <= wb_data_i;
      end
   end

   assign ra_data_o = mem_q[ra_addr_i];
   assign rb_data_o = mem_q[rb_addr_i];
   assign rc_data_o = mem_q[rc_addr_i];

endmodule

// File: rtl/ptr_list_writer.sv
// ---------------------------------------------------------------------------
// ptr_list_writer
// Allocates and frees nodes of singly linked lists held in a shared
// next-pointer table, with a LIFO free list threaded through that table.
//   clk, rst        clock, synchronous active-high reset
//   cmd_vld/cmd_rdy command handshake (ready only in IDLE)
//   cmd_op          0 NEW, 1 APPEND, 2 FREE, 3 reserved (error)
//   cmd_ptr         APPEND: current tail; FREE: list head
//   rsp_vld         one-cycle registered response pulse per command
//   rsp_ptr         allocated node / freed head / 0 on error
//   rsp_err         command rejected
//   free_cnt        number of nodes on the free list
//   rd_ptr/rd_next  traversal port, rd_next = next[rd_ptr]
// ---------------------------------------------------------------------------
module ptr_list_writer
   import ptr_list_writer_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_vld,
   output logic       cmd_rdy,
   input  logic [1:0] cmd_op,
   input  ptr_t       cmd_ptr,
   output logic       rsp_vld,
   output ptr_t       rsp_ptr,
   output logic       rsp_err,
   output ptr_t       free_cnt,
   input  ptr_t       rd_ptr,
   output ptr_t       rd_next
);

   state_e state_q;
   ptr_t   free_head_q;
   ptr_t   free_cnt_q;
   ptr_t   cur_q;
   ptr_t   walk_head_q;
   logic   rsp_vld_q;
   ptr_t   rsp_ptr_q;
   logic   rsp_err_q;

   ptr_t    fh_next;   // next[free_head]
   ptr_t    lk_addr;   // cur during a walk, otherwise the command pointer
   ptr_t    lk_next;
   cmd_op_e op;
   logic    accept, alloc, app_ok, new_ok, free_go, walking;
   logic    wa_en, wb_en;
   ptr_t    wa_addr, wa_data;

   assign op      = cmd_op_e'(cmd_op);
   assign walking = (state_q == ST_FREE_WALK);
   assign accept  = cmd_vld && (state_q == ST_IDLE);
   assign lk_addr = walking ? cur_q : cmd_ptr;

   assign new_ok  = accept && op == OP_NEW && free_head_q != '0;
   assign app_ok  = accept && op == OP_APPEND && free_head_q != '0 &&
                    cmd_ptr != '0 && lk_next == '0;
   assign alloc   = new_ok || app_ok;
   assign free_go = accept && op == OP_FREE && cmd_ptr != '0;

   // Port A either detaches the allocated node (next[p] <= 0) or, during a
   // walk, pushes cur onto the free list. Port B links an old tail to p.
   always_comb begin
      wa_en   = 1'b0;
      wa_addr = free_head_q;
      wa_data = '0;
      if (walking) begin
         wa_en   = 1'b1;
         wa_addr = cur_q;
         wa_data = free_head_q;
      end else if (alloc) begin
         wa_en   = 1'b1;
      end
   end

   assign wb_en = app_ok;

   ptr_table u_table (
      .clk       (clk),
      .rst       (rst),
      .wa_en_i   (wa_en),
      .wa_addr_i (wa_addr),
      .wa_data_i (wa_data),
      .wb_en_i   (wb_en),
      .wb_addr_i (cmd_ptr),
      .wb_data_i (free_head_q),
      .ra_addr_i (free_head_q),
      .ra_data_o (fh_next),
      .rb_addr_i (lk_addr),
      .rb_data_o (lk_next),
      .rc_addr_i (rd_ptr),
      .rc_data_o (rd_next)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         free_head_q <= ptr_t'(1);
         free_cnt_q  <= ptr_t'(n - 1);
         cur_q       <= '0;
         walk_head_q <= '0;
         rsp_vld_q   <= 1'b0;
         rsp_ptr_q   <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         rsp_vld_q <= 1'b0;
         rsp_ptr_q <= '0;
         rsp_err_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (alloc) begin
                  free_head_q <= fh_next;
                  free_cnt_q  <= free_cnt_q - ptr_t'(1);
                  rsp_vld_q   <= 1'b1;
                  rsp_ptr_q   <= free_head_q;
               end else if (free_go) begin
                  // No response yet; it follows the last walked node.
                  state_q     <= ST_FREE_WALK;
                  cur_q       <= cmd_ptr;
                  walk_head_q <= cmd_ptr;
               end else if (accept) begin
                  rsp_vld_q   <= 1'b1;
                  rsp_err_q   <= 1'b1;
               end
            end
            ST_FREE_WALK: begin
               free_head_q <= cur_q;
               cur_q       <= lk_next;
               free_cnt_q  <= free_cnt_q + ptr_t'(1);
               if (lk_next == '0) begin
                  state_q   <= ST_IDLE;
                  rsp_vld_q <= 1'b1;
                  rsp_ptr_q <= walk_head_q;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign cmd_rdy  = (state_q == ST_IDLE);
   assign rsp_vld  = rsp_vld_q;
   assign rsp_ptr  = rsp_ptr_q;
   assign rsp_err  = rsp_err_q;
   assign free_cnt = free_cnt_q;

endmodule

// File: tb/tb_ptr_list_writer.sv
// ---------------------------------------------------------------------------
// tb_ptr_list_writer
// Scoreboard bench for ptr_list_writer: each command pushes its expected
// response; a monitor pops and compares whenever rsp_vld is seen.
// ---------------------------------------------------------------------------
module tb_ptr_list_writer;
   import ptr_list_writer_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cmd_vld = 1'b0;
   logic       cmd_rdy;
   logic [1:0] cmd_op = 2'd0;
   ptr_t       cmd_ptr = '0;
   logic       rsp_vld;
   ptr_t       rsp_ptr;
   logic       rsp_err;
   ptr_t       free_cnt;
   ptr_t       rd_ptr = '0;
   ptr_t       rd_next;

   typedef struct packed {
      logic err;
      ptr_t ptr;
   } rsp_t;

   rsp_t exp_q[$];
   rsp_t mon_e;
   int   n_tests = 0;
   int   n_fail  = 0;

   ptr_list_writer dut (
      .clk      (clk),
      .rst      (rst),
      .cmd_vld  (cmd_vld),
      .cmd_rdy  (cmd_rdy),
      .cmd_op   (cmd_op),
      .cmd_ptr  (cmd_ptr),
      .rsp_vld  (rsp_vld),
      .rsp_ptr  (rsp_ptr),
      .rsp_err  (rsp_err),
      .free_cnt (free_cnt),
      .rd_ptr   (rd_ptr),
      .rd_next  (rd_next)
   );

   always #5 clk = ~clk;

   // Response monitor / scoreboard.
   always @(negedge clk) begin
      if (!rst && rsp_vld === 1'b1) begin
         n_tests++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_rsp: got ptr=%0d err=%0b, required no response", rsp_ptr, rsp_err);
         end else begin
            mon_e = exp_q.pop_front();
            if ({rsp_err, rsp_ptr} !== mon_e) begin
               n_fail++;
               $display("FAIL rsp: got ptr=%0d err=%0b, required ptr=%0d err=%0b",
                        rsp_ptr, rsp_err, mon_e.ptr, mon_e.err);
            end
         end
      end else if (!rst && (rsp_ptr !== '0 || rsp_err !== 1'b0)) begin
         n_tests++;
         n_fail++;
         $display("FAIL idle_rsp: got ptr=%0d err=%0b with rsp_vld low, required 0/0", rsp_ptr, rsp_err);
      end
   end

   task automatic reset_dut();
      rst     = 1'b1;
      cmd_vld = 1'b0;
      cmd_op  = 2'd0;
      cmd_ptr = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // Called at a negedge; returns at the negedge after acceptance.
   task automatic issue(input logic [1:0] op, input ptr_t p, input bit push,
                        input logic e_err, input ptr_t e_ptr);
      int guard = 0;
      while (cmd_rdy !== 1'b1 && guard < 1000) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 1000) begin
         n_tests++;
         n_fail++;
         $display("FAIL rdy_timeout: cmd_rdy=%0b, required 1 within 1000 cycles", cmd_rdy);
      end
      cmd_vld = 1'b1;
      cmd_op  = op;
      cmd_ptr = p;
      if (push) exp_q.push_back({e_err, e_ptr});
      @(negedge clk);
      cmd_vld = 1'b0;
   endtask

   task automatic drain();
      int guard = 0;
      while (exp_q.size() != 0 && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d responses outstanding, required 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_reset();
      ptr_t ra [6] = '{8'd0, 8'd1, 8'd2, 8'd128, 8'd254, 8'd255};
      ptr_t rx [6] = '{8'd0, 8'd2, 8'd3, 8'd129, 8'd255, 8'd0};
      reset_dut();
      n_tests++;
      if (cmd_rdy !== 1'b1 || rsp_vld !== 1'b0 || rsp_ptr !== '0 || rsp_err !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: rdy=%0b vld=%0b ptr=%0d err=%0b, required 1 0 0 0",
                  cmd_rdy, rsp_vld, rsp_ptr, rsp_err);
      end
      n_tests++;
      if (free_cnt !== 8'd255) begin
         n_fail++;
         $display("FAIL reset_free_cnt: got %0d, required 255", free_cnt);
      end
      for (int i = 0; i < 6; i++) begin
         rd_ptr = ra[i];
         #1;
         n_tests++;
         if (rd_next !== rx[i]) begin
            n_fail++;
            $display("FAIL reset_next[%0d]: got %0d, required %0d", ra[i], rd_next, rx[i]);
         end
      end
      @(negedge clk);
   endtask

   task automatic test_new();
      reset_dut();
      for (int i = 1; i <= 3; i++) issue(2'd0, '0, 1'b1, 1'b0, ptr_t'(i));
      drain();
      n_tests++;
      if (free_cnt !== 8'd252) begin
         n_fail++;
         $display("FAIL new_free_cnt: got %0d, required 252", free_cnt);
      end
      rd_ptr = 8'd1;
      #1;
      n_tests++;
      if (rd_next !== 8'd0) begin
         n_fail++;
         $display("FAIL new_next1: got %0d, required 0", rd_next);
      end
      @(negedge clk);
   endtask

   task automatic test_append();
      ptr_t ca [3] = '{8'd1, 8'd2, 8'd3};
      ptr_t cx [3] = '{8'd2, 8'd3, 8'd0};
      reset_dut();
      issue(2'd0, 8'd0, 1'b1, 1'b0, 8'd1);
      issue(2'd1, 8'd1, 1'b1, 1'b0, 8'd2);
      issue(2'd1, 8'd2, 1'b1, 1'b0, 8'd3);
      drain();
      for (int i = 0; i < 3; i++) begin
         rd_ptr = ca[i];
         #1;
         n_tests++;
         if (rd_next !== cx[i]) begin
            n_fail++;
            $display("FAIL chain_next[%0d]: got %0d, required %0d", ca[i], rd_next, cx[i]);
         end
      end
      @(negedge clk);
   endtask

   task automatic test_errors();
      issue(2'd1, 8'd1, 1'b1, 1'b1, 8'd0);   // not a tail
      issue(2'd1, 8'd0, 1'b1, 1'b1, 8'd0);   // null tail
      issue(2'd3, 8'd5, 1'b1, 1'b1, 8'd0);   // reserved op
      issue(2'd2, 8'd0, 1'b1, 1'b1, 8'd0);   // free null
      drain();
      n_tests++;
      if (free_cnt !== 8'd252) begin
         n_fail++;
         $display("FAIL err_free_cnt: got %0d, required 252", free_cnt);
      end
      rd_ptr = 8'd1;
      #1;
      n_tests++;
      if (rd_next !== 8'd2) begin
         n_fail++;
         $display("FAIL err_next1: got %0d, required 2", rd_next);
      end
      @(negedge clk);
   endtask

   task automatic test_free();
      int k = 0;
      issue(2'd2, 8'd1, 1'b1, 1'b0, 8'd1);
      while (cmd_rdy === 1'b0 && k < 100) begin
         k++;
         @(negedge clk);
      end
      n_tests++;
      if (k != 3) begin
         n_fail++;
         $display("FAIL free_busy_cycles: got %0d, required 3", k);
      end
      drain();
      n_tests++;
      if (free_cnt !== 8'd255) begin
         n_fail++;
         $display("FAIL free_cnt_after_free: got %0d, required 255", free_cnt);
      end
      issue(2'd0, 8'd0, 1'b1, 1'b0, 8'd3);   // LIFO: last freed node first
      drain();
   endtask

   task automatic test_back_to_back_exhaust();
      reset_dut();
      for (int i = 1; i <= 255; i++) issue(2'd0, 8'd0, 1'b1, 1'b0, ptr_t'(i));
      issue(2'd0, 8'd0, 1'b1, 1'b1, 8'd0);
      issue(2'd1, 8'd255, 1'b1, 1'b1, 8'd0);
      drain();
      n_tests++;
      if (free_cnt !== 8'd0) begin
         n_fail++;
         $display("FAIL exhaust_free_cnt: got %0d, required 0", free_cnt);
      end
   endtask

   task automatic test_rst_walk();
      int seen = 0;
      reset_dut();
      issue(2'd0, 8'd0, 1'b1, 1'b0, 8'd1);
      for (int i = 1; i <= 4; i++) issue(2'd1, ptr_t'(i), 1'b1, 1'b0, ptr_t'(i + 1));
      drain();
      n_tests++;
      if (free_cnt !== 8'd250) begin
         n_fail++;
         $display("FAIL walk_setup_free_cnt: got %0d, required 250", free_cnt);
      end
      issue(2'd2, 8'd1, 1'b0, 1'b0, 8'd0);
      @(negedge clk);
      n_tests++;
      if (cmd_rdy !== 1'b0) begin
         n_fail++;
         $display("FAIL walk_busy: cmd_rdy=%0b, required 0", cmd_rdy);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (rsp_vld !== 1'b0) seen++;
         @(negedge clk);
      end
      n_tests++;
      if (seen != 0) begin
         n_fail++;
         $display("FAIL walk_abort_rsp: got %0d response cycles, required 0", seen);
      end
      n_tests++;
      if (free_cnt !== 8'd255 || cmd_rdy !== 1'b1) begin
         n_fail++;
         $display("FAIL walk_abort_state: free_cnt=%0d rdy=%0b, required 255 1", free_cnt, cmd_rdy);
      end
      issue(2'd0, 8'd0, 1'b1, 1'b0, 8'd1);
      drain();
   endtask

   initial begin
      test_reset();
      test_new();
      test_append();
      test_errors();
      test_free();
      test_back_to_back_exhaust();
      test_rst_walk();
      repeat (2) @(negedge clk);
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL leftover_expect: %0d outstanding, required 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
